// File: rtl/regfile_dump_reader.sv
// ---------------------------------------------------------------------------
// regfile_dump_reader
//
// Sequential read-out engine for the 16 x 8-bit RegisterFile. A start command
// latches an inclusive register range (wrapping 15 -> 0). For each register
// it issues one DumpReg strobe, captures the byte returned on rf_out the
// following cycle, and presents it on a valid/ready byte stream.
//
// Optional feature (macro DUMP_CHECKSUM_EN): after the last data beat an
// extra beat carrying the XOR of all bytes dumped in this run is sent, and
// dout_last marks that checksum beat instead of the last data beat.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous reset, active low
//   start      in   1  begin a dump (sampled only when idle)
//   first_reg  in   4  first register index (sampled with start)
//   last_reg   in   4  last register index, inclusive (sampled with start)
//   rf_out     in   8  RegisterFile read data, valid the cycle after DumpReg
//   DumpReg    out  1  read strobe to RegisterFile
//   RegNumber  out  4  register index to RegisterFile
//   dout       out  8  streamed byte
//   dout_valid out  1  dout holds a valid beat
//   dout_ready in   1  consumer accepts the beat
//   dout_last  out  1  final beat of the dump
//   busy       out  1  dump in progress
//   done       out  1  one-cycle completion pulse
// ---------------------------------------------------------------------------
module regfile_dump_reader (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] first_reg,
   input  logic [3:0] last_reg,
   input  logic [7:0] rf_out,
   output logic       DumpReg,
   output logic [3:0] RegNumber,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       dout_last,
   output logic       busy,
   output logic       done
);

`ifdef DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_SEND, ST_DONE, ST_CHK} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_SEND, ST_DONE} state_t;
`endif

   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] end_q, end_d;
   logic [7:0] dout_q, dout_d;
   logic       dout_valid_q, dout_valid_d;
   logic       dout_last_q, dout_last_d;
   logic       dump_reg_q, dump_reg_d;
   logic [3:0] reg_number_q, reg_number_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;
`endif

   // All outputs are computed one cycle ahead so that every port is driven
   // straight from a flop; the index advances at the handshake so the next
   // REQ already carries the incremented register number.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      end_d        = end_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      dout_last_d  = dout_last_q;
      dump_reg_d   = 1'b0;
      reg_number_d = reg_number_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_d       = csum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d        = first_reg;
               end_d        = last_reg;
               dump_reg_d   = 1'b1;
               reg_number_d = first_reg;
               busy_d       = 1'b1;
               state_d      = ST_REQ;
`ifdef DUMP_CHECKSUM_EN
               csum_d       = 8'h00;
`endif
            end
         end

         ST_REQ: begin
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            dout_d       = rf_out;
            dout_valid_d = 1'b1;
`ifdef DUMP_CHECKSUM_EN
            dout_last_d  = 1'b0;
            csum_d       = csum_q ^ rf_out;
`else
            dout_last_d  = (idx_q == end_q);
`endif
            state_d      = ST_SEND;
         end

         ST_SEND: begin
            if (dout_ready) begin
               dout_valid_d = 1'b0;
               dout_last_d  = 1'b0;
               if (idx_q == end_q) begin
`ifdef DUMP_CHECKSUM_EN
                  dout_d       = csum_q;
                  dout_valid_d = 1'b1;
                  dout_last_d  = 1'b1;
                  state_d      = ST_CHK;
`else
                  done_d       = 1'b1;
                  state_d      = ST_DONE;
`endif
               end else begin
                  idx_d        = idx_q + 4'd1;
                  dump_reg_d   = 1'b1;
                  reg_number_d = idx_q + 4'd1;
                  state_d      = ST_REQ;
               end
            end
         end

`ifdef DUMP_CHECKSUM_EN
         ST_CHK: begin
            if (dout_ready) begin
               dout_valid_d = 1'b0;
               dout_last_d  = 1'b0;
               done_d       = 1'b1;
               state_d      = ST_DONE;
            end
         end
`endif

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= 4'd0;
         end_q        <= 4'd0;
         dout_q       <= 8'h00;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         dump_reg_q   <= 1'b0;
         reg_number_q <= 4'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q       <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         end_q        <= end_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         dout_last_q  <= dout_last_d;
         dump_reg_q   <= dump_reg_d;
         reg_number_q <= reg_number_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef DUMP_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign DumpReg    = dump_reg_q;
   assign RegNumber  = reg_number_q;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign dout_last  = dout_last_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the 16 x 8-bit RegisterFile. On a start command it walks a programmable register range, drives `DumpReg`/`RegNumber` on the register file's read side, captures each returned byte, and streams it out over a valid/ready byte interface to a debug or host port. It is the read-side counterpart of the load path (`LoadReg`/`in`) and sits between the RegisterFile and the debug output channel.

## Interface
- Clocking (decided): one clock; reset is asynchronous and active-low. Ports are `clk` and `reset`; `reset` = 0 resets the block.
- No parameters; widths are fixed (4-bit register index, 8-bit data).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `first_reg`  in  4  first register index; sampled with `start`.
- `last_reg`  in  4  last register index, inclusive; sampled with `start`.
- `rf_out`  in  8  RegisterFile `out` bus.
- `DumpReg`  out  1  read strobe to RegisterFile.
- `RegNumber`  out  4  register index to RegisterFile.
- `dout`  out  8  streamed byte.
- `dout_valid`  out  1  `dout` holds a valid beat.
- `dout_ready`  in  1  consumer accepts the beat.
- `dout_last`  out  1  marks the final beat of a dump.
- `busy`  out  1  high from the cycle after accepted `start` until DONE exits.
- `done`  out  1  one-cycle pulse at dump completion.

## Operation
- States: IDLE, REQ, WAIT, SEND, (CHK), DONE.
- IDLE: `start`=1 latches `first_reg` into the index counter and `last_reg` into the end register -> REQ.
- REQ: `DumpReg`=1, `RegNumber`=index for exactly one cycle -> WAIT.
- WAIT: `rf_out` is valid this cycle; capture it into `dout` at the clock edge -> SEND.
- SEND: `dout_valid`=1; `dout` stays stable until `dout_valid && dout_ready`. On handshake: if index == end, go to CHK when `DUMP_CHECKSUM_EN` is defined, otherwise to DONE. Else increment index (4-bit, 15 wraps to 0) -> REQ.
- `dout_last`=1 only in SEND on the final data beat, or in CHK when enabled.
- DONE: `done`=1 for one cycle -> IDLE.
- Range: `first_reg` == `last_reg` gives one beat. `last_reg` < `first_reg` wraps through 15->0; for example 14..1 yields 14, 15, 0, 1. A full 16-register dump uses `last_reg` = `first_reg` - 1 (mod 16).
- `start` while busy is ignored; the latched range is not changed.
- `RegNumber` holds its last driven value when idle. `DumpReg` is 0 outside REQ.

## Timing
- Reset values: `DumpReg`=0, `RegNumber`=0, `dout`=0x00, `dout_valid`=0, `dout_last`=0, `busy`=0, `done`=0; state IDLE.
- Start to first `DumpReg`: 1 cycle. `DumpReg` to `dout_valid`: 2 cycles.
- With `dout_ready` held high, each register takes 3 cycles (REQ, WAIT, SEND). An N-register dump plus DONE takes 3N+1 cycles after start.
- Backpressure: SEND may hold indefinitely; no new `DumpReg` is issued while a beat is pending.
- Reset mid-dump: outputs return to reset values immediately (asynchronous); a partial stream is abandoned with no `done`.
- `dout_valid` never deasserts without a handshake, except on reset.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - After the last data beat, CHK presents one extra beat: `dout` = XOR of all bytes dumped in this run, `dout_valid`=1, `dout_last`=1.
  - The accumulator clears on accepted `start`.
  - On handshake -> DONE. Adds 1 cycle minimum.
- `DUMP_CHECKSUM_EN` undefined: no CHK state and no accumulator; `dout_last` is asserted on the last data beat.

## Test plan
- Reset then single register: RF[1]=0xCC; start with first=last=1, `dout_ready`=1 -> one beat 0xCC with `dout_last`=1. `DumpReg` is high exactly one cycle with `RegNumber`=1; `done` pulses 4 cycles after start.
- Wrap range: RF[14]=0x11, RF[15]=0xF0, RF[0]=0x22, RF[1]=0xCC; first=14, last=1 -> beats 0x11, 0xF0, 0x22, 0xCC in order; `dout_last` only on 0xCC.
- Backpressure: hold `dout_ready`=0 for 5 cycles in SEND -> `dout` and `dout_valid` stable, no further `DumpReg`; the stream resumes correctly after release.
- Start while busy: pulse `start` with a different range mid-dump -> ignored; the original range completes unchanged.
- Reset mid-dump: assert `reset`=0 during the second beat -> all outputs return to reset values at once with no `done`; a new start afterwards dumps correctly.
- Checksum (`DUMP_CHECKSUM_EN` defined): dump 0xCC, 0xF0 -> third beat 0x3C with `dout_last`=1; `done` follows.
